// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the fetch stage
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } ifu_state_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  // Branch immediates count words, not bytes
  localparam int BR_SHIFT = 2;

endpackage

// File: rtl/instruction_fetch_unit_pc_next_calc.sv
// rtl/instruction_fetch_unit_pc_next_calc.sv - combinational sequential/branch PC computation
module pc_next_calc
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] offset;

  // All sums wrap modulo 2^ADDR_W; negative immediates give backward branches
  assign pc_plus4 = pc + ADDR_W'(4);
  assign offset   = {{(ADDR_W-16){imm[15]}}, imm} << BR_SHIFT;
  assign pc_next  = branch_taken ? (pc_plus4 + offset) : pc_plus4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage with req/ack imem port; optional HALT via IFU_HALT_EN
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted
);

  ifu_state_t        state;
  ifu_state_t        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              consume;

  // An issued instruction leaves the stage on the first ISSUE edge without stall
  assign consume = (state == ISSUE) && !stall;

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_calc (
    .pc          (pc),
    .imm         (instr[15:0]),
    .branch_taken(branch_taken),
    .pc_plus4    (pc_plus4),
    .pc_next     (pc_nxt)
  );

  // State register; reset clears it asynchronously so imem_req drops at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs (no input reaches an output directly)
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
`ifdef IFU_HALT_EN
          if (instr[31:26] == HALT_OPCODE) begin
            state_nxt = HALT;
          end else begin
            state_nxt = FETCH;
          end
`else
          state_nxt = FETCH;
`endif
        end
      end
      HALT: begin
`ifdef IFU_HALT_EN
        halted = 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC advances only when the issued instruction is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (consume) begin
      pc <= pc_nxt;
    end
  end

  // Instruction register captures the word on the acknowledging FETCH edge only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= '0;
    end else if ((state == FETCH) && imem_ack) begin
      instr <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign opCode    = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the single-cycle MIPS core. Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word to decode. Decode receives `opCode`/`funct` for the control unit. The unit advances the PC by +4, or to the branch target when downstream resolves a taken `beq`.

## Interface
- `ADDR_W`, 32: PC and instruction-memory byte-address width.
- `RESET_PC`, 0: PC value after reset. Must be word aligned.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out ADDR_W: byte address of the word being fetched. Bits [1:0] are always 0.
- `imem_ack` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: decode/execute cannot accept a new instruction.
- `branch_taken` in 1: the issued instruction is a taken branch (Branch & zero).
- `instr_valid` out 1: `instr`, `opCode`, `funct`, `pc_plus4` are valid.
- `instr` out 32: registered instruction word.
- `opCode` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `pc_plus4` out ADDR_W: address of the issued instruction + 4.
- `halted` out 1: the fetch unit has stopped (only with `IFU_HALT_EN`).

## Operation
- States: IDLE, FETCH, ISSUE, HALT (HALT exists only with the macro).
- IDLE:
  - Entered on reset.
  - Goes to FETCH on the first edge after reset deasserts.
- FETCH:
  - `imem_req`=1, `imem_addr`=PC.
  - On an edge where `imem_ack`=1: latch `imem_rdata` into `instr`, then go to ISSUE.
  - `imem_ack` is ignored in every other state.
- ISSUE:
  - `instr_valid`=1.
  - While `stall`=1: hold every output and the PC.
  - On an edge with `stall`=0, the instruction is consumed:
    - PC ← PC+4+(sext(`instr[15:0]`)<<2) if `branch_taken`=1, else PC+4.
    - Then go to FETCH.
- `branch_taken` is sampled only on the consuming edge of ISSUE.
- PC arithmetic is modulo 2^ADDR_W. Wrap past the top of the address space is silent. Backward branches use two's-complement offsets.
- `pc_plus4` = PC+4 of the issued instruction, same wrap rule.
- Reset values:
  - PC=`RESET_PC`, state IDLE.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=0, so `opCode`=0 and `funct`=0.
  - `instr_valid`=0, `pc_plus4`=`RESET_PC`+4, `halted`=0.
- Reset mid-FETCH: `imem_req` drops immediately (asynchronous). Instruction memory must discard the outstanding request.
- Reset mid-ISSUE: the instruction is dropped and never re-issued.

## Timing
- Minimum 2 cycles per instruction: 1 FETCH cycle with same-cycle ack, then 1 ISSUE cycle.
- Each extra cycle of `imem_ack` latency or of `stall` adds one cycle.
- The address for the next fetch appears on `imem_addr` in the cycle after the consuming ISSUE edge.
- Outputs are registered; there is no combinational path from `imem_rdata` or `stall` to any output.
- `stall` and `branch_taken` asserted together: `stall` wins, and the branch is re-sampled on the consuming edge.

## Configuration
- `IFU_HALT_EN` defined:
  - Opcode 6'h3F on the consuming ISSUE edge moves the unit to HALT.
  - In HALT: `imem_req`=0, `instr_valid`=0, `halted`=1.
  - HALT is left only by reset.
- `IFU_HALT_EN` undefined:
  - No HALT state; 6'h3F is issued like any other opcode.
  - `halted` is tied to 0.

## Structure
- Shared package holds:
  - state encoding enum: IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, HALT=2'd3.
  - opcode constant for halt: 6'h3F.
  - branch offset shift (2).
- One natural sub-module: `pc_next_calc`, combinational. Computes PC+4 and the branch target from PC, `instr[15:0]` and `branch_taken`.

## Test plan
- Reset release, memory acks same cycle:
  - First request at `imem_addr`=0x0.
  - `instr_valid` pulses every 2nd cycle.
  - Addresses run 0x0, 0x4, 0x8.
- Ack delayed 3 cycles at 0x4: `imem_req` stays high for 4 cycles; `instr` changes only on the ack edge.
- `stall` held 5 cycles during ISSUE: outputs and PC stay constant; exactly one instruction is consumed after release.
- Taken branch at PC 0x10 with imm 0xFFFE: next fetch address 0x0C. With imm 0x0003: next fetch address 0x20.
- `RESET_PC`=0xFFFFFFFC, no branch: `pc_plus4`=0x0, and the next fetch address wraps to 0x0.
- Reset asserted mid-FETCH: `imem_req` goes low before the next edge. After release, fetch restarts at `RESET_PC`.
- With `IFU_HALT_EN`, word 0xFC000000 issued: `halted`=1, and there are no further requests.
